// File: rtl/display_pkg.sv
// Shared constants for the multiplexed 7-segment display path.
// Glyphs are active-low and ordered {g,f,e,d,c,b,a}.
package display_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int SCAN_W     = $clog2(NUM_DIGITS);

   typedef logic [SCAN_W-1:0] scan_idx_t;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // One frame's worth of formatter output, captured together.
   typedef struct packed {
      logic       neg;
      logic [3:0] hundreds;
      logic [3:0] tens;
      logic [3:0] units;
   } digits_t;

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low 7-segment glyph; codes above 9 render as 'E'.
// Purely combinational, zero latency, no flow control.
module seg7_decoder
   import display_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_E;
      case (i_bcd)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_E;
      endcase
   end

endmodule

// File: rtl/bcd_display_scanner.sv
// Scans sign + 3 BCD digits onto a 4-digit multiplexed display, snapshotting once per frame.
// an/seg are registered (1-cycle latency); free-running scan, no backpressure.
module bcd_display_scanner
   import display_pkg::*;
#(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 64
)(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_enable,
   input  logic       i_negative,
   input  logic [3:0] i_bcd_hundreds,
   input  logic [3:0] i_bcd_tens,
   input  logic [3:0] i_bcd_units,
   output logic [3:0] o_an,
   output logic [6:0] o_seg,
   output logic       o_dp
);

   localparam int                CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_BLANK = CNT_W'(BLANK_CYCLES);
   localparam scan_idx_t         IDX_LAST  = scan_idx_t'(NUM_DIGITS - 1);

   logic [CNT_W-1:0] r_refresh_cnt;
   scan_idx_t        r_scan_idx;
   digits_t          r_snap;

   logic       w_slot_end;
   logic       w_frame_end;
   logic       w_show_h;
   logic       w_show_t;
   logic       w_dark;
   logic [6:0] w_seg_h;
   logic [6:0] w_seg_t;
   logic [6:0] w_seg_u;
   logic [6:0] w_slot_seg;
   logic [3:0] w_an_next;
   logic [6:0] w_seg_next;

   assign w_slot_end  = (r_refresh_cnt == CNT_LAST);
   assign w_frame_end = w_slot_end && (r_scan_idx == IDX_LAST);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_refresh_cnt <= '0;
         r_scan_idx    <= '0;
         r_snap        <= '0;
      end else begin
         if (w_slot_end) begin
            r_refresh_cnt <= '0;
            r_scan_idx    <= (r_scan_idx == IDX_LAST) ? '0 : r_scan_idx + 1'b1;
         end else begin
            r_refresh_cnt <= r_refresh_cnt + 1'b1;
         end
         // Capture only at the frame boundary so a frame never mixes two values.
         if (w_frame_end) begin
            r_snap.neg      <= i_negative;
            r_snap.hundreds <= i_bcd_hundreds;
            r_snap.tens     <= i_bcd_tens;
            r_snap.units    <= i_bcd_units;
         end
      end
   end

   seg7_decoder u_dec_h (.i_bcd(r_snap.hundreds), .o_seg(w_seg_h));
   seg7_decoder u_dec_t (.i_bcd(r_snap.tens),     .o_seg(w_seg_t));
   seg7_decoder u_dec_u (.i_bcd(r_snap.units),    .o_seg(w_seg_u));

   assign w_show_h = (r_snap.hundreds != 4'd0);
   assign w_show_t = w_show_h | (r_snap.tens != 4'd0);

   // The minus sign sits immediately left of the leading shown digit.
   always_comb begin
      w_slot_seg = SEG_BLANK;
      case (r_scan_idx)
         2'd0: w_slot_seg = w_seg_u;
         2'd1: begin
            if (w_show_t)        w_slot_seg = w_seg_t;
            else if (r_snap.neg) w_slot_seg = SEG_MINUS;
            else                 w_slot_seg = SEG_BLANK;
         end
         2'd2: begin
            if (w_show_h)                    w_slot_seg = w_seg_h;
            else if (r_snap.neg && w_show_t) w_slot_seg = SEG_MINUS;
            else                             w_slot_seg = SEG_BLANK;
         end
         default: begin
            if (r_snap.neg && w_show_h) w_slot_seg = SEG_MINUS;
            else                        w_slot_seg = SEG_BLANK;
         end
      endcase
   end

   assign w_dark     = (r_refresh_cnt < CNT_BLANK) || !i_enable;
   assign w_an_next  = w_dark ? 4'b1111 : ~(4'b0001 << r_scan_idx);
   assign w_seg_next = w_dark ? SEG_BLANK : w_slot_seg;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_an  <= 4'b1111;
         o_seg <= SEG_BLANK;
         o_dp  <= 1'b1;
      end else begin
         o_an  <= w_an_next;
         o_seg <= w_seg_next;
         o_dp  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomised + directed scoreboard bench for bcd_display_scanner (REFRESH_DIV=8, BLANK_CYCLES=2).
module tb_bcd_display_scanner;

   localparam int DIV   = 8;
   localparam int BLANK = 2;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       negative;
   logic [3:0] bcd_h;
   logic [3:0] bcd_t;
   logic [3:0] bcd_u;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   done   = 0;

   // Reference model state: edges since reset, plus the digits the current frame displays.
   int   n = 0;
   logic mN = 0;
   int   mH = 0, mT = 0, mU = 0;

   bcd_display_scanner #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
      .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_negative(negative),
      .i_bcd_hundreds(bcd_h), .i_bcd_tens(bcd_t), .i_bcd_units(bcd_u),
      .o_an(an), .o_seg(seg), .o_dp(dp)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   function automatic logic [6:0] glyph(input int v);
      case (v)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b0000110;
      endcase
   endfunction

   // Text-level view: digits up to the leading nonzero position, then '-', then blanks.
   function automatic logic [6:0] slot_glyph(input int slot, input logic neg, input int h, input int t, input int u);
      int digs[3];
      int lead;
      digs = '{u, t, h};
      lead = (h != 0) ? 2 : ((t != 0) ? 1 : 0);
      if (slot <= lead) return glyph(digs[slot]);
      if (neg && slot == lead + 1) return 7'b0111111;
      return 7'b1111111;
   endfunction

   // Predict the output after the coming edge, queue it, then advance one clock.
   task automatic step();
      exp_t e;
      int   cnt, idx;
      e = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1};
      if (reset) begin
         n = 0; mN = 0; mH = 0; mT = 0; mU = 0;
      end else begin
         cnt = n % DIV;
         idx = (n / DIV) % 4;
         if (cnt >= BLANK && enable) begin
            e.an  = ~(4'(1) << idx);
            e.seg = slot_glyph(idx, mN, mH, mT, mU);
         end
         if (cnt == DIV - 1 && idx == 3) begin
            mN = negative; mH = int'(bcd_h); mT = int'(bcd_t); mU = int'(bcd_u);
         end
         n++;
      end
      q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) step();
   endtask

   task automatic set_in(input logic ng, input int h, input int t, input int u);
      negative = ng; bcd_h = 4'(h); bcd_t = 4'(t); bcd_u = 4'(u);
   endtask

   // Monitor: one registered output per clock, compared against the queued prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
               errors++;
               $display("FAIL outputs t=%0t: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                        $time, an, seg, dp, e.an, e.seg, e.dp);
            end
         end
      end
   end

   initial begin
      reset = 1; enable = 1;
      set_in(1'b0, 0, 0, 0);
      @(negedge clk);
      run(3);
      reset = 0;
      set_in(1'b1, 9, 9, 9);
      run(13);
      // Reset mid-slot, then the first frame must show the cleared snapshot.
      reset = 1;
      run(3);
      reset = 0;
      set_in(1'b1, 1, 2, 8);
      run(32 + 64);
      set_in(1'b1, 0, 0, 5);
      run(64);
      set_in(1'b0, 0, 4, 2);
      run(40);
      for (int k = 0; k < 64; k++) begin
         if (n % DIV == 3 && (n / DIV) % 4 == 1) break;
         step();
      end
      set_in(1'b0, 0, 9, 9);
      run(48);
      enable = 0;
      run(20);
      enable = 1;
      run(20);
      set_in(1'b0, 0, 11, 3);
      run(64);
      set_in(1'b0, 0, 0, 0);
      run(64);
      set_in(1'b0, 1, 2, 7);
      run(64);
      // Frame-boundary load coinciding with an enable change.
      for (int k = 0; k < 64; k++) begin
         if (n % DIV == DIV - 1 && (n / DIV) % 4 == 3) break;
         step();
      end
      enable = 0;
      set_in(1'b1, 3, 0, 0);
      step();
      enable = 1;
      run(40);
      // Random phase: values, sign, invalid codes, enable glitches, occasional reset.
      for (int it = 0; it < 80; it++) begin
         int h, t, u;
         h = ($urandom_range(0, 9) < 4) ? 0 : $urandom_range(0, 15);
         t = ($urandom_range(0, 9) < 3) ? 0 : $urandom_range(0, 15);
         u = $urandom_range(0, 15);
         set_in(1'($urandom_range(0, 1)), h, t, u);
         enable = ($urandom_range(0, 9) != 0);
         reset  = ($urandom_range(0, 39) == 0);
         run($urandom_range(1, 24));
         reset  = 0;
      end
      enable = 1;
      run(40);
      done = 1;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d predictions left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
